// File: rtl/hw_spi_pkg.sv
// Shared constants, frame geometry and FSM state type for the APP FPGA SPI status slave.
package hw_spi_pkg;

  localparam logic [6:0] ADDR_STATUS0 = 7'h00;
  localparam logic [6:0] ADDR_STATUS1 = 7'h01;
  localparam logic [6:0] ADDR_STATUS2 = 7'h02;
  localparam logic [6:0] ADDR_STATUS3 = 7'h03;
  localparam logic [6:0] ADDR_STATUS4 = 7'h04;
  localparam logic [6:0] ADDR_STATUS5 = 7'h05;
  localparam logic [6:0] ADDR_STATUS6 = 7'h06;
  localparam logic [6:0] ADDR_STATUS7 = 7'h07;
  localparam logic [6:0] ADDR_CTRL    = 7'h08;
  localparam logic [6:0] ADDR_ID      = 7'h7F;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned RW_BIT     = 7;

  typedef enum logic [2:0] {
    WAIT_CS,
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_e;

endpackage

// File: rtl/app_spi_status_slave_if.sv
// SPI0 link between the APP FPGA (master) and this board (slave).
interface app_spi_status_slave_if;

  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall pulses
// taken from the last stage against one further registered copy.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/app_spi_status_slave.sv
// SPI mode-0 slave, oversampled in CLK_100M: 16-bit frames read 8-bit pages of the
// board status vector, the ID byte, or write the loop-control register.
module app_spi_status_slave
  import hw_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter logic [7:0]  CTRL_RESET  = 8'h00
) (
  input  logic                   CLK_100M,
  input  logic                   RST_N,
  app_spi_status_slave_if.slave  spi,
  input  logic [63:0]            status_in,
  output logic [7:0]             ctrl_out,
  output logic                   wr_strobe,
  output logic                   rd_strobe,
  output logic                   frame_err
);

  logic unused_sclk_level;
  logic sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sclk_sync (
    .clk   (CLK_100M),
    .rst_n (RST_N),
    .din   (spi.spi_sclk),
    .level (unused_sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_cs_sync (
    .clk   (CLK_100M),
    .rst_n (RST_N),
    .din   (spi.spi_cs_n),
    .level (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Same depth as sclk so the bit seen at a synced rise is the one the master set up.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
    end
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic        overrun_q, overrun_d;
  logic        miso_q, miso_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        err_q, err_d;

  logic [7:0]  shift_byte;
  logic        last_cmd_bit;
  logic        last_frame_bit;
  logic [7:0]  rd_byte;

  assign shift_byte     = {rx_q[6:0], mosi_s};
  assign last_cmd_bit   = (bit_cnt_q == 5'(CMD_BITS - 1));
  assign last_frame_bit = (bit_cnt_q == 5'(FRAME_BITS - 1));

  // Read mux addressed by the command byte as it completes, so the snapshot is one cycle.
  always_comb begin
    rd_byte = 8'h00;
    case (shift_byte[6:0])
      ADDR_STATUS0: rd_byte = status_in[7:0];
      ADDR_STATUS1: rd_byte = status_in[15:8];
      ADDR_STATUS2: rd_byte = status_in[23:16];
      ADDR_STATUS3: rd_byte = status_in[31:24];
      ADDR_STATUS4: rd_byte = status_in[39:32];
      ADDR_STATUS5: rd_byte = status_in[47:40];
      ADDR_STATUS6: rd_byte = status_in[55:48];
      ADDR_STATUS7: rd_byte = status_in[63:56];
      ADDR_CTRL:    rd_byte = ctrl_q;
      ADDR_ID:      rd_byte = ID_VALUE;
      default:      rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_CS;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_CS: if (cs_s) state_d = IDLE;
      IDLE:    if (cs_fall) state_d = CMD;
      CMD: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise && last_cmd_bit) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // A completing rise wins over a coincident cs_n rise.
        if (sclk_rise && last_frame_bit) begin
          state_d = cs_rise ? IDLE : DONE;
        end else if (cs_rise) begin
          state_d = IDLE;
        end
      end
      DONE:    if (cs_rise) state_d = IDLE;
      default: state_d = WAIT_CS;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    overrun_d = overrun_q;
    miso_d    = miso_q;
    ctrl_d    = ctrl_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      WAIT_CS: miso_d = 1'b0;
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          bit_cnt_d = '0;
          rx_d      = '0;
          tx_d      = '0;
          overrun_d = 1'b0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          err_d  = 1'b1;
          miso_d = 1'b0;
        end else if (sclk_rise) begin
          rx_d      = shift_byte;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (last_cmd_bit) begin
            rw_d   = shift_byte[RW_BIT];
            addr_d = shift_byte[6:0];
            tx_d   = shift_byte[RW_BIT] ? rd_byte : 8'h00;
            rd_d   = shift_byte[RW_BIT];
          end
        end
      end
      DATA: begin
        if (sclk_rise && last_frame_bit) begin
          rx_d      = shift_byte;
          bit_cnt_d = bit_cnt_q + 5'd1;
          miso_d    = 1'b0;
          if (!rw_q && (addr_q == ADDR_CTRL)) begin
            ctrl_d = shift_byte;
            wr_d   = 1'b1;
          end
        end else if (cs_rise) begin
          err_d  = 1'b1;
          miso_d = 1'b0;
        end else if (sclk_rise) begin
          rx_d      = shift_byte;
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (sclk_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          err_d     = overrun_q | sclk_rise;
          overrun_d = 1'b0;
        end else if (sclk_rise) begin
          overrun_d = 1'b1;
        end
      end
      default: miso_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
      miso_q    <= 1'b0;
      ctrl_q    <= CTRL_RESET;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
      miso_q    <= miso_d;
      ctrl_q    <= ctrl_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

  assign spi.spi_miso = miso_q;
  assign ctrl_out     = ctrl_q;
  assign wr_strobe    = wr_q;
  assign rd_strobe    = rd_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_app_spi_status_slave.sv
// Scoreboard bench: a behavioural SPI master issues frames and queues the expected
// strobes and read bytes; a monitor pops and compares as the slave responds.
module tb_app_spi_status_slave;

  localparam int HALF = 10;  // SCLK half period in CLK_100M cycles (5 MHz)

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] status;
  logic [7:0]  ctrl_out;
  logic        wr_strobe, rd_strobe, frame_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] ctrl_m;
  logic [7:0] exp_wr_q[$];
  int         exp_rd_q[$];
  int         exp_err_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] obs_miso_q[$];

  always #5 clk = ~clk;

  app_spi_status_slave_if spi_bus ();

  app_spi_status_slave #(
    .SYNC_STAGES (2),
    .ID_VALUE    (8'hA5),
    .CTRL_RESET  (8'h00)
  ) dut (
    .CLK_100M  (clk),
    .RST_N     (rst_n),
    .spi       (spi_bus),
    .status_in (status),
    .ctrl_out  (ctrl_out),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_status();
    return {$urandom, $urandom} & 64'h1FFF_FFFF_FFFF_FFFF;
  endfunction

  // Register map as seen by the APP FPGA.
  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a < 7'd8)       return status[a*8 +: 8];
    else if (a == 7'h08) return ctrl_m;
    else if (a == 7'h7F) return 8'hA5;
    else                 return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_strobe) begin
        check("wr_strobe expected", 64'(exp_wr_q.size() > 0), 1);
        if (exp_wr_q.size() > 0) check("ctrl_out at wr_strobe", ctrl_out, exp_wr_q.pop_front());
      end
      if (rd_strobe) begin
        check("rd_strobe expected", 64'(exp_rd_q.size() > 0), 1);
        if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_front());
      end
      if (frame_err) begin
        check("frame_err expected", 64'(exp_err_q.size() > 0), 1);
        if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
      end
      while (obs_miso_q.size() > 0 && exp_miso_q.size() > 0)
        check("miso read byte", obs_miso_q.pop_front(), exp_miso_q.pop_front());
    end
  end

  // nbits < 16 aborts, > 16 overruns; rst_at >= 0 resets the DUT before that rise.
  task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                          input bit toggle, input int rst_at);
    logic [15:0] word;
    logic [15:0] rxw;
    word = {b0, b1};
    rxw  = '0;
    if (rst_at < 0) begin
      if (b0[7] && nbits >= 8) exp_rd_q.push_back(1);
      if (nbits >= 16) begin
        if (b0[7]) begin
          exp_miso_q.push_back(model_read(b0[6:0]));
        end else if (b0[6:0] == 7'h08) begin
          ctrl_m = b1;
          exp_wr_q.push_back(b1);
        end
      end
      if (nbits != 16) exp_err_q.push_back(1);
    end
    spi_bus.spi_cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bus.spi_mosi = (i < 16) ? word[15-i] : 1'b1;
      wait_clks(HALF);
      if (i == rst_at) begin
        rst_n = 1'b0;
        wait_clks(2);
        check("ctrl_out in mid-frame reset", ctrl_out, 8'h00);
        check("miso in mid-frame reset", spi_bus.spi_miso, 1'b0);
        rst_n  = 1'b1;
        ctrl_m = 8'h00;
        wait_clks(2);
      end
      spi_bus.spi_sclk = 1'b1;
      if (i < 16) rxw[15-i] = spi_bus.spi_miso;
      if (toggle && i == 8) status = rand_status();
      wait_clks(HALF);
      spi_bus.spi_sclk = 1'b0;
    end
    wait_clks(HALF);
    spi_bus.spi_cs_n = 1'b1;
    wait_clks(4 * HALF);
    check("miso idle after frame", spi_bus.spi_miso, 1'b0);
    if (rst_at < 0 && b0[7] && nbits >= 16) obs_miso_q.push_back(rxw[7:0]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    int         sel;
    int         nb;
    rst_n            = 1'b0;
    status           = 64'h0;
    ctrl_m           = 8'h00;
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    wait_clks(5);
    check("reset ctrl_out", ctrl_out, 8'h00);
    check("reset wr_strobe", wr_strobe, 1'b0);
    check("reset rd_strobe", rd_strobe, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset miso", spi_bus.spi_miso, 1'b0);
    rst_n = 1'b1;
    wait_clks(10);

    do_frame(8'hFF, 8'h00, 16, 1'b0, -1);
    do_frame(8'h08, 8'h3C, 16, 1'b0, -1);
    check("ctrl_out after write", ctrl_out, ctrl_m);
    do_frame(8'h88, 8'h00, 16, 1'b0, -1);
    status = 64'h0123_4567_89AB_CDEF;
    do_frame(8'h81, 8'h00, 16, 1'b1, -1);
    do_frame(8'h08, 8'hFF, 11, 1'b0, -1);
    check("ctrl_out after abort", ctrl_out, ctrl_m);
    do_frame(8'h03, 8'h55, 18, 1'b0, -1);
    do_frame(8'h90, 8'h00, 16, 1'b0, -1);
    do_frame(8'h08, 8'h77, 16, 1'b0, 11);
    check("ctrl_out after reset frame", ctrl_out, ctrl_m);
    do_frame(8'h08, 8'h5A, 16, 1'b0, -1);
    do_frame(8'h88, 8'h00, 16, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 11));
      if (sel <= 8)      a = 7'(sel);
      else if (sel == 9) a = 7'h7F;
      else               a = 7'($urandom);
      case ($urandom_range(0, 7))
        0:       nb = int'($urandom_range(1, 15));
        1:       nb = int'($urandom_range(17, 19));
        default: nb = 16;
      endcase
      status = rand_status();
      do_frame({1'($urandom), a}, 8'($urandom), nb, 1'($urandom), -1);
    end

    wait_clks(20);
    check("pending wr_strobe", exp_wr_q.size(), 0);
    check("pending rd_strobe", exp_rd_q.size(), 0);
    check("pending frame_err", exp_err_q.size(), 0);
    check("pending read byte", exp_miso_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/app_spi_status_slave.md
Name: app_spi_status_slave

Overview:
- SPI mode-0 slave (responder) on the APP FPGA SPI0 link; the APP FPGA is the master.
- Lets the APP FPGA read the registered board input status (loop states, door/switch inputs, config DIP switches) in 8-bit pages.
- Lets the APP FPGA write one 8-bit control register that drives loop-control outputs in top_hw.
- Fully oversampled in the CLK_100M domain; no logic is clocked by SCLK.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi (minimum 2).
- ID_VALUE, 8'hA5, constant returned at address 0x7F.
- CTRL_RESET, 8'h00, reset value of the control register.

Ports:
- CLK_100M  in  1  system clock, 100 MHz.
- RST_N  in  1  reset; asynchronous, active-low.
- spi_sclk  in  1  SPI clock from the APP FPGA; max 10 MHz, idle low.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data; 0 when not shifting.
- status_in  in  64  registered input vector; bits 63:61 tie 0.
- ctrl_out  out  8  control register contents.
- wr_strobe  out  1  one-cycle pulse when ctrl_out updates.
- rd_strobe  out  1  one-cycle pulse when a read address is latched.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset values: spi_miso=0, ctrl_out=CTRL_RESET, all strobes 0, state=WAIT_CS, shift registers and bit counter 0.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - rise/fall pulses come from the last stage versus one further registered copy.
  - Edge-to-action latency is SYNC_STAGES+1 cycles.
  - SCLK high and low times must each be ≥5 CLK_100M cycles.
- Frame format: 16 bits, MSB first.
  - Byte 0 = {rw, addr[6:0]}; rw=1 read, rw=0 write.
  - Byte 1 = write data (MOSI) or read data (MISO).
- Sampling: MOSI is sampled on the synced sclk rise. MISO changes only on the synced sclk fall, or at cs_n fall for the first byte.
- States:
  - WAIT_CS: wait for synced cs_n=1, then go to IDLE. This guarantees resync after reset or an abort in mid-frame.
  - IDLE: on cs_n fall, clear bit_cnt and go to CMD. MISO=0.
  - CMD: shift 8 MOSI bits. At the 8th rise, latch rw/addr.
    - For a read: snapshot the selected byte into tx_shift and pulse rd_strobe.
    - Go to DATA.
  - DATA: on each fall, drive tx_shift[7] and shift left. Bit 7 is driven on the fall after the 8th rise. On each rise, shift MOSI into rx_shift. At the 16th rise:
    - Write to 0x08: ctrl_out <= rx_shift and pulse wr_strobe on the same cycle.
    - Other write addresses: ignored, no strobe.
    - Go to DONE.
  - DONE: MISO=0 and further sclk edges are ignored. Any rise seen in DONE sets an overrun flag. On cs_n rise, pulse frame_err if overrun, then go to IDLE.
- Read map:
  - 0x00..0x07 return status_in[8n+7:8n].
  - 0x08 returns ctrl_out.
  - 0x7F returns ID_VALUE.
  - All other addresses return 0x00.
- Coherence: the selected status byte is captured in a single cycle at the 8th rise. It does not change during the shift-out even if status_in toggles.
- Abort: cs_n rise in CMD or DATA before the 16th rise pulses frame_err, performs no write, forces MISO=0, and goes to IDLE.
- Simultaneous events: a cs_n rise and the 16th rise in the same cycle complete the frame first (write and wr_strobe), with no frame_err. A cs_n fall in DONE without a prior rise is impossible after sync and is treated as IDLE.
- Reset in mid-frame: all state returns to reset values and the FSM goes to WAIT_CS. The in-flight frame is discarded.

Decomposition:
- Package hw_spi_pkg holds:
  - address constants ADDR_STATUS0..7, ADDR_CTRL=7'h08, ADDR_ID=7'h7F;
  - FRAME_BITS=16 and the RW_BIT index;
  - the FSM state enum {WAIT_CS, IDLE, CMD, DATA, DONE}.
- Sub-module spi_sync_edge holds the SYNC_STAGES synchronizer plus rise/fall detect. It is instantiated for sclk and cs_n; mosi uses a synchronizer only.

Test Plan:
- Read ID: cs low, send 0xFF then 0x00 at 5 MHz -> MISO byte 1 = 0xA5, rd_strobe pulses once, frame_err never asserts.
- Write/readback: write frame 0x08,0x3C -> ctrl_out=0x3C with a one-cycle wr_strobe. A following read frame 0x88 -> MISO returns 0x3C.
- Status snapshot: status_in=64'h0123_4567_89AB_CDEF, read 0x81 -> 0xCD. Toggle status_in during byte 1 -> the returned value is still 0xCD.
- Abort: raise cs_n after 11 clocks of write 0x08,0xFF -> frame_err pulses once, ctrl_out is unchanged, MISO=0.
- Overrun and RO write: write 0x03,0x55 with 18 clocks -> no wr_strobe, frame_err pulses at cs rise. Read 0x10 -> 0x00.
- Reset in mid-frame: assert RST_N low during the DATA state -> ctrl_out=0x00 and MISO=0. No response until cs_n is seen high. The next full frame works.
